uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready FIFO front end feeding an LSB-first serialiser.
// Optional parity bit is compiled in with `UART_TX_PARITY_EN (PARITY_ODD selects odd sense).
module uart_tx_fifo #(
  parameter int BAUD       = 104,
  parameter int DW         = 8,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 4,
  parameter int GAP        = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            data,
  input  logic                     valid,
  output logic                     ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW       = $clog2(DEPTH);
  localparam int STOP_LEN = STOP_BITS * BAUD;
  localparam int CMAX     = (STOP_LEN > GAP) ? STOP_LEN : GAP;
  localparam int CW       = $clog2(CMAX + 1);
  localparam int IW       = $clog2(DW);

  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(BAUD - 1);
  localparam logic [CW-1:0] CNT_STOP = CW'(STOP_LEN - 1);
  localparam logic [CW-1:0] CNT_GAP  = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

`ifdef UART_TX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  function automatic logic parity_f(input logic [DW-1:0] w);
    return (^w) ^ ODD_BIT;
  endfunction
`endif

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          push_s, pop_s, empty_s, bit_end_s, start_next_s;
  logic [DW-1:0] head_s;

  assign ready     = !full_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign level     = level_q;
  assign push_s    = valid && !full_q;
  assign empty_s   = (level_q == '0);
  assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
  assign bit_end_s = (cnt_q == CNT_BIT);

  // FIFO storage; only words accepted by the handshake are written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data;
    end
  end

  // FIFO pointer, occupancy and full-flag next state
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    level_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Serialiser FSM: next state, bit timing and the registered tx value
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sh_d         = sh_q;
    par_d        = par_q;
    tx_d         = tx_q;
    pop_s        = 1'b0;
    start_next_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_s) begin
          start_next_s = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // bit i always sits in sh_q[0] after i shifts
            idx_d = idx_q + IDX_ONE;
            sh_d  = {1'b0, sh_q[DW-1:1]};
            tx_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_STOP) begin
          cnt_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
            tx_d    = 1'b1;
          end else if (!empty_s) begin
            start_next_s = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_GAP) begin
          cnt_d = '0;
          if (!empty_s) begin
            start_next_s = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Common frame launch: pop the head word and drive the start bit
    if (start_next_s) begin
      pop_s   = 1'b1;
      sh_d    = head_s;
      state_d = S_START;
      cnt_d   = '0;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = parity_f(head_s);
`endif
    end else begin
      pop_s = 1'b0;
    end

    busy_d = (state_d != S_IDLE) || (level_d != '0);
  end

  // State registers with synchronous reset; reset also aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: two instances (8-bit/1 stop/no gap, 5-bit/2 stop/gap 10).
// Stimulus pushes expected frames into per-instance queues; monitors decode tx and compare.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BAUD    = 4;
  localparam int GAP_B   = 10;
  localparam int FRAME_A = (1 + 8 + PB + 1) * BAUD;
  localparam int FRAME_B = (1 + 5 + PB + 2) * BAUD;

  typedef struct {
    logic [7:0] d;
    int         start;
    bit         b2b;
  } item_t;

  logic       clk = 1'b0;
  logic [1:0] rst_r = 2'b11;
  logic [1:0] valid_r = 2'b00;
  logic [1:0] ready_w, tx_w, busy_w;
  logic [7:0] data_a = 8'h00;
  logic [4:0] data_b = 5'h00;
  logic [2:0] level_a, level_b;
  int         cyc = 0;
  int         checks_n = 0;
  int         errs_n = 0;
  item_t      q0 [$];
  item_t      q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.BAUD(BAUD), .DW(8), .STOP_BITS(1), .DEPTH(4), .GAP(0), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst_r[0]), .data(data_a), .valid(valid_r[0]), .ready(ready_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .level(level_a));

  uart_tx_fifo #(.BAUD(BAUD), .DW(5), .STOP_BITS(2), .DEPTH(4), .GAP(GAP_B), .PARITY_ODD(1)) u_b (
    .clk(clk), .rst(rst_r[1]), .data(data_b), .valid(valid_r[1]), .ready(ready_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .level(level_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      errs_n++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input int k, input logic [7:0] d, input bit chk_start, input bit b2b,
                      output int acc);
    item_t it;
    int    n;
    n = 0;
    valid_r[k] = 1'b1;
    while (!ready_w[k] && n < 400) begin
      if (k == 0) data_a = ~d; else data_b = ~d[4:0];
      @(negedge clk);
      n++;
    end
    if (k == 0) data_a = d; else data_b = d[4:0];
    if (!ready_w[k]) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid_r[k] = 1'b0;
    acc = cyc;
    it.d     = (k == 0) ? d : (d & 8'h1F);
    it.start = chk_start ? acc + 1 : -1;
    it.b2b   = b2b;
    if (k == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while (busy_w[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", {31'd0, busy_w[k]}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Frame decoder: samples every cycle of every bit so a glitch or stretched bit is caught
  task automatic mon(input int k);
    int         dw, nbits, frame, gap, sc, prev_sc;
    logic [15:0] bits;
    logic [7:0] got;
    logic       glitch, aborted, stop_ok, v, odd;
    item_t      it;
    dw      = (k == 0) ? 8 : 5;
    nbits   = 1 + dw + PB + ((k == 0) ? 1 : 2);
    frame   = (k == 0) ? FRAME_A : FRAME_B;
    gap     = (k == 0) ? 0 : GAP_B;
    odd     = (k == 0) ? 1'b0 : 1'b1;
    prev_sc = -100000;
    forever begin
      @(negedge clk);
      if (!rst_r[k] && tx_w[k] == 1'b0) begin
        sc = cyc; glitch = 1'b0; aborted = 1'b0; bits = 16'h0000;
        for (int b = 0; b < nbits; b++) begin
          for (int c = 0; c < BAUD; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            v = tx_w[k];
            if (rst_r[k]) aborted = 1'b1;
            if (c == 0) bits[b] = v;
            else if (v !== bits[b]) glitch = 1'b1;
          end
        end
        if (!aborted) begin
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            it = (k == 0) ? q0.pop_front() : q1.pop_front();
            got = 8'h00;
            for (int i = 0; i < dw; i++) got[i] = bits[1 + i];
            stop_ok = 1'b1;
            for (int i = 1 + dw + PB; i < nbits; i++) if (bits[i] !== 1'b1) stop_ok = 1'b0;
            chk("bit_stable", {31'd0, glitch}, 32'd0);
            chk("data", {24'd0, got}, {24'd0, it.d});
            chk("stop_bits", {31'd0, stop_ok}, 32'd1);
`ifdef UART_TX_PARITY_EN
            chk("parity", {31'd0, bits[1 + dw]}, {31'd0, (^it.d) ^ odd});
`endif
            if (it.start >= 0) chk("start_latency", sc, it.start);
            if (it.b2b) chk("b2b_start", sc, prev_sc + frame + gap);
          end
          prev_sc = sc;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, t, s, low_n;
    repeat (3) @(negedge clk);
    // reset state while reset is held
    chk("rst_tx_a", {31'd0, tx_w[0]}, 32'd1);
    chk("rst_ready_a", {31'd0, ready_w[0]}, 32'd1);
    chk("rst_busy_a", {31'd0, busy_w[0]}, 32'd0);
    chk("rst_level_a", {29'd0, level_a}, 32'd0);
    chk("rst_tx_b", {31'd0, tx_w[1]}, 32'd1);
    chk("rst_busy_b", {31'd0, busy_w[1]}, 32'd0);
    chk("rst_level_b", {29'd0, level_b}, 32'd0);
    rst_r = 2'b00;
    @(negedge clk);

    // single word 0x55: start at E+1, busy drops right after the stop bit
    push(0, 8'h55, 1'b1, 1'b0, a1);
    while (cyc < a1 + FRAME_A) @(negedge clk);
    chk("busy_last_stop", {31'd0, busy_w[0]}, 32'd1);
    @(negedge clk);
    chk("busy_after_stop", {31'd0, busy_w[0]}, 32'd0);
    chk("tx_idle", {31'd0, tx_w[0]}, 32'd1);

    // parity word on the even-parity instance
    push(0, 8'h07, 1'b1, 1'b0, t);
    wait_idle(0, 200);

    // backpressure: five pushes fill the FIFO behind the frame in flight
    push(0, 8'h81, 1'b1, 1'b0, a1);
    push(0, 8'h42, 1'b0, 1'b1, t);
    push(0, 8'h24, 1'b0, 1'b1, t);
    push(0, 8'h18, 1'b0, 1'b1, t);
    push(0, 8'hC3, 1'b0, 1'b1, t);
    chk("full_level", {29'd0, level_a}, 32'd4);
    chk("full_ready", {31'd0, ready_w[0]}, 32'd0);
    push(0, 8'h3C, 1'b0, 1'b1, t);
    chk("sixth_accept_cycle", t, a1 + 2 + FRAME_A);
    wait_idle(0, 600);

    // gap/2 stop bits/5-bit width on instance B; upper producer bits dropped
    push(1, 8'hA3, 1'b1, 1'b0, t);
    push(1, 8'h0F, 1'b0, 1'b1, t);
    push(1, 8'hFF, 1'b0, 1'b1, t);
    push(1, 8'h07, 1'b0, 1'b1, t);
    chk("b_level", {29'd0, level_b}, 32'd3);
    wait_idle(1, 600);

    // reset during data bit 3 of 0x00 with two words queued
    push(0, 8'h00, 1'b1, 1'b0, a1);
    push(0, 8'h5A, 1'b0, 1'b1, t);
    push(0, 8'hA5, 1'b0, 1'b1, t);
    s = a1 + 1;
    while (cyc < s + 4 * (1 + 3) + 1) @(negedge clk);
    rst_r[0] = 1'b1;
    @(negedge clk);
    chk("midrst_tx", {31'd0, tx_w[0]}, 32'd1);
    chk("midrst_level", {29'd0, level_a}, 32'd0);
    chk("midrst_ready", {31'd0, ready_w[0]}, 32'd1);
    chk("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
    q0.delete();
    @(negedge clk);
    rst_r[0] = 1'b0;
    low_n = 0;
    repeat (80) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) low_n++;
    end
    chk("no_frame_after_rst", low_n, 32'd0);
    chk("busy_after_rst", {31'd0, busy_w[0]}, 32'd0);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs_n, checks_n);
    $finish;
  end

endmodule
